// File: rtl/dispatch_queue_pkg.sv
// Shared dispatch-side definitions: lane width, queue depth and the decoded packet format.
package dispatch_queue_pkg;

    localparam int unsigned SYS_N_WAY            = 2;
    localparam int unsigned DISPATCH_QUEUE_DEPTH = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  dest_reg_idx;
        logic [2:0]  fu_sel;
    } DISPATCH_PACKET_R10K;

endpackage

// File: rtl/dispatch_queue_leading_ones_count.sv
// leading_ones_count: number of consecutive set bits starting at bit 0.
module leading_ones_count #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0]             i_bits,
    output logic [$clog2(W+1)-1:0]   o_count
);

    logic w_run;

    always_comb begin
        o_count = '0;
        w_run   = 1'b1;
        for (int i = 0; i < W; i++) begin
            w_run = w_run & i_bits[i];
            if (w_run) o_count = o_count + 1'b1;
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order decoded-instruction buffer feeding R10K dispatch, N_WAY lanes in and out.
// Optional same-cycle bypass of an empty queue: define DISPATCH_QUEUE_BYPASS_EN.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int unsigned N_WAY = SYS_N_WAY,
    parameter int unsigned DEPTH = DISPATCH_QUEUE_DEPTH
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush,
    input  DISPATCH_PACKET_R10K [N_WAY-1:0]     enq_packet,
    output logic                                enq_ready,
    output DISPATCH_PACKET_R10K [N_WAY-1:0]     dispatch_packet,
    input  logic [N_WAY-1:0]                    dispatched,
    output logic [$clog2(DEPTH):0]              free_slots,
    output logic                                empty,
    output logic                                full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LC_W  = $clog2(N_WAY + 1);

    DISPATCH_PACKET_R10K r_entries [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;

    logic                w_bypass;
    logic [N_WAY-1:0]    w_enq_valid;
    logic [N_WAY-1:0]    w_lane_valid;
    logic [LC_W-1:0]     w_enq_lead;
    logic [LC_W-1:0]     w_e;
    logic [LC_W-1:0]     w_d;
    logic [LC_W-1:0]     w_skip;
    logic [LC_W-1:0]     w_head_adv;

    // Status depends only on registered count, never on same-cycle dequeue.
    assign free_slots = CNT_W'(DEPTH) - r_count;
    assign enq_ready  = (free_slots >= CNT_W'(N_WAY));
    assign empty      = (r_count == '0);
    assign full       = (r_count == CNT_W'(DEPTH));

    always_comb begin
        w_bypass = 1'b0;
`ifdef DISPATCH_QUEUE_BYPASS_EN
        w_bypass = (r_count == '0) && !flush;
`endif
        for (int i = 0; i < N_WAY; i++) begin
            w_enq_valid[i] = enq_packet[i].valid;
            if (w_bypass) begin
                dispatch_packet[i] = enq_packet[i];
            end else begin
                dispatch_packet[i]       = r_entries[r_head + PTR_W'(i)];
                dispatch_packet[i].valid = (CNT_W'(i) < r_count);
            end
            w_lane_valid[i] = dispatch_packet[i].valid;
        end
    end

    leading_ones_count #(
        .W (N_WAY)
    ) u_enq_count (
        .i_bits  (w_enq_valid),
        .o_count (w_enq_lead)
    );

    // Masking with lane validity and counting only the leading run enforces in-order retire.
    leading_ones_count #(
        .W (N_WAY)
    ) u_deq_count (
        .i_bits  (dispatched & w_lane_valid),
        .o_count (w_d)
    );

    // Lanes retired straight out of the bypass are never written to storage.
    assign w_e        = enq_ready ? w_enq_lead : '0;
    assign w_skip     = w_bypass ? w_d : '0;
    assign w_head_adv = w_bypass ? '0 : w_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) r_entries[j] <= '0;
        end else if (!flush) begin
            for (int i = 0; i < N_WAY; i++) begin
                if ((LC_W'(i) >= w_skip) && (LC_W'(i) < w_e)) begin
                    r_entries[r_tail + PTR_W'(LC_W'(i) - w_skip)] <= enq_packet[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_head_adv);
            r_tail  <= r_tail + PTR_W'(w_e - w_skip);
            r_count <= r_count + CNT_W'(w_e) - CNT_W'(w_d);
        end
    end

    a_enq_prefix: assert property (@(posedge clock) disable iff (reset)
        (w_enq_valid & (w_enq_valid + N_WAY'(1))) == '0);

    a_count_bound: assert property (@(posedge clock) disable iff (reset)
        r_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized self-checking bench for dispatch_queue against a queue-based reference model.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam int N = SYS_N_WAY;
    localparam int D = DISPATCH_QUEUE_DEPTH;

    logic                            clock;
    logic                            reset;
    logic                            flush;
    DISPATCH_PACKET_R10K [N-1:0]     enq_packet;
    logic                            enq_ready;
    DISPATCH_PACKET_R10K [N-1:0]     dispatch_packet;
    logic [N-1:0]                    dispatched;
    logic [$clog2(D):0]              free_slots;
    logic                            empty;
    logic                            full;

    dispatch_queue #(
        .N_WAY (N),
        .DEPTH (D)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .enq_packet      (enq_packet),
        .enq_ready       (enq_ready),
        .dispatch_packet (dispatch_packet),
        .dispatched      (dispatched),
        .free_slots      (free_slots),
        .empty           (empty),
        .full            (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    DISPATCH_PACKET_R10K mq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] next_pc  = 32'h1000;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus just after a falling edge, check, then advance the model.
    task automatic step(input bit do_reset, input bit do_flush, input int k,
                        input logic [N-1:0] disp);
        DISPATCH_PACKET_R10K p   [N];
        DISPATCH_PACKET_R10K exp_pkt;
        bit                  exp_v [N];
        bit                  byp;
        bit                  rdy;
        int                  d;
        int                  e;
        for (int i = 0; i < N; i++) begin
            p[i].valid        = (i < k);
            p[i].pc           = next_pc + 32'(4 * i);
            p[i].inst         = $urandom;
            p[i].dest_reg_idx = 5'($urandom);
            p[i].fu_sel       = 3'($urandom);
            enq_packet[i]     = p[i];
        end
        reset      = do_reset;
        flush      = do_flush;
        dispatched = disp;
        #1;
        byp = 1'b0;
`ifdef DISPATCH_QUEUE_BYPASS_EN
        byp = (mq.size() == 0) && !do_flush;
`endif
        rdy = ((D - mq.size()) >= N);
        for (int i = 0; i < N; i++) begin
            exp_v[i] = byp ? (i < k) : (i < mq.size());
            check_eq($sformatf("lane%0d_valid", i), 64'(dispatch_packet[i].valid), 64'(exp_v[i]));
            if (exp_v[i]) begin
                exp_pkt = byp ? p[i] : mq[i];
                check_eq($sformatf("lane%0d_pc", i), 64'(dispatch_packet[i].pc), 64'(exp_pkt.pc));
                check_eq($sformatf("lane%0d_inst", i), 64'(dispatch_packet[i].inst),
                         64'(exp_pkt.inst));
            end
        end
        check_eq("enq_ready", 64'(enq_ready), 64'(rdy));
        check_eq("free_slots", 64'(free_slots), 64'(D - mq.size()));
        check_eq("empty", 64'(empty), 64'(mq.size() == 0));
        check_eq("full", 64'(full), 64'(mq.size() == D));
        d = 0;
        for (int i = 0; i < N; i++) begin
            if (disp[i] && exp_v[i] && d == i) d++;
        end
        e = rdy ? k : 0;
        @(posedge clock);
        if (do_reset || do_flush) begin
            mq.delete();
        end else if (byp) begin
            for (int i = d; i < e; i++) mq.push_back(p[i]);
        end else begin
            for (int i = 0; i < d; i++) void'(mq.pop_front());
            for (int i = 0; i < e; i++) mq.push_back(p[i]);
        end
        next_pc = next_pc + 32'(4 * N);
        @(negedge clock);
    endtask

    initial begin
        int k;
        reset      = 1'b1;
        flush      = 1'b0;
        dispatched = '0;
        enq_packet = '0;
        repeat (2) @(negedge clock);
        mq.delete();

        // Reset state, then fill to full without retiring.
        step(1'b0, 1'b0, 0, '0);
        repeat (4) step(1'b0, 1'b0, N, '0);
        step(1'b0, 1'b0, N, '0);
        // Out-of-order acceptance is ignored, then partial and full retires.
        step(1'b0, 1'b0, 0, 2'b10);
        step(1'b0, 1'b0, 0, 2'b01);
        step(1'b0, 1'b0, N, 2'b11);
        step(1'b0, 1'b0, 0, 2'b11);
        step(1'b0, 1'b0, N, 2'b11);
        // Flush mid-stream with competing enqueue and dequeue.
        step(1'b0, 1'b1, N, 2'b11);
        step(1'b0, 1'b0, 0, 2'b00);
        // Empty-queue enqueue with partial same-cycle acceptance.
        step(1'b0, 1'b0, N, 2'b01);
        step(1'b0, 1'b0, 0, 2'b00);
        // Wrap-around stream: alternate full retire / hold.
        for (int c = 0; c < 20; c++) step(1'b0, 1'b0, N, (c % 2 == 0) ? 2'b11 : 2'b00);

        for (int c = 0; c < 600; c++) begin
            k = $urandom_range(N, 0);
            step(($urandom_range(99, 0) == 0), ($urandom_range(99, 0) < 3), k,
                 N'($urandom));
        end
        // Mid-stream reset.
        step(1'b1, 1'b0, N, 2'b11);
        step(1'b0, 1'b0, 0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
